// File: rtl/fp_div_if.sv
// rtl/fp_div_if.sv - start/busy/done handshake and operand/result bundle for fp_div
interface fp_div_if;
    logic        start;
    logic [31:0] operando_a;
    logic [31:0] operando_b;
    logic        busy;
    logic        done;
    logic [31:0] resultado;
    logic        div_by_zero;
    logic        invalid;

    modport master (
        output start, operando_a, operando_b,
        input  busy, done, resultado, div_by_zero, invalid
    );

    modport slave (
        input  start, operando_a, operando_b,
        output busy, done, resultado, div_by_zero, invalid
    );
endinterface

// File: rtl/fp_div.sv
// rtl/fp_div.sv - sequential IEEE-754 single divider, restoring shift-subtract, RNE, FTZ; optional FP_DIV_EARLY_TERM_EN
module fp_div #(
    parameter int Q_BITS = 27
) (
    input  logic     clock,
    input  logic     reset,
    fp_div_if.slave  bus
);
    localparam int CW = $clog2(Q_BITS + 1);

    typedef enum logic [2:0] {IDLE, SPECIAL, DIVIDE, NORM, ROUND, DONE} state_t;

    state_t              state;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic signed [9:0]   exp_q;
    logic [25:0]         rem_q;
    logic [24:0]         div_q;
    logic [Q_BITS-1:0]   quo_q;
    logic [CW-1:0]       cnt_q;
    logic [23:0]         sig_q;
    logic                guard_q;
    logic                sticky_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         res_q;
    logic                dbz_q;
    logic                inv_q;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.resultado   = res_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.invalid     = inv_q;

    logic        sign;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        sp_hit, sp_inv, sp_dbz;
    logic [31:0] sp_res;

    // Operand classification; exponent 0 counts as zero so denormals flush
    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        a_zero = (a_q[30:23] == 8'd0);
        b_zero = (b_q[30:23] == 8'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        sp_hit = 1'b1;
        sp_inv = 1'b0;
        sp_dbz = 1'b0;
        sp_res = 32'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res = 32'h7FC00000;
            sp_inv = 1'b1;
        end else if (a_inf) begin
            sp_res = {sign, 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
            sp_res = {sign, 31'd0};
        end else if (b_zero) begin
            sp_res = {sign, 8'hFF, 23'd0};
            sp_dbz = 1'b1;
        end else begin
            sp_hit = 1'b0;
        end
    end

    logic              rem_ge;
    logic [25:0]       rem_sub;
    logic [25:0]       rem_next;
    logic [Q_BITS-1:0] quo_next;

    // One restoring step: compare, conditionally subtract, shift remainder left
    always_comb begin
        rem_ge   = (rem_q >= {1'b0, div_q});
        rem_sub  = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
        rem_next = {rem_sub[24:0], 1'b0};
        quo_next = {quo_q[Q_BITS-2:0], rem_ge};
    end

    logic [Q_BITS-1:0] quo_norm;
    logic signed [9:0] exp_norm;

    // Bring the integer bit to 1 when the quotient came out below 1.0
    always_comb begin
        quo_norm = quo_q;
        exp_norm = exp_q;
        if (!quo_q[Q_BITS-1]) begin
            quo_norm = {quo_q[Q_BITS-2:0], 1'b0};
            exp_norm = exp_q - 10'sd1;
        end
    end

    logic              round_up;
    logic [24:0]       sig_sum;
    logic [23:0]       sig_rnd;
    logic signed [9:0] exp_rnd;
    logic [31:0]       norm_res;

    // Round to nearest even, then clamp the exponent to inf or flushed zero
    always_comb begin
        round_up = guard_q & (sticky_q | sig_q[0]);
        sig_sum  = {1'b0, sig_q} + {24'd0, round_up};
        sig_rnd  = sig_sum[23:0];
        exp_rnd  = exp_q;
        if (sig_sum[24]) begin
            sig_rnd = 24'h800000;
            exp_rnd = exp_q + 10'sd1;
        end
        if (exp_rnd >= 10'sd255) begin
            norm_res = {sign, 8'hFF, 23'd0};
        end else if (exp_rnd <= 10'sd0) begin
            norm_res = {sign, 31'd0};
        end else begin
            norm_res = {sign, exp_rnd[7:0], sig_rnd[22:0]};
        end
    end

    // Control FSM with registered handshake outputs and datapath updates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            exp_q    <= 10'sd0;
            rem_q    <= 26'd0;
            div_q    <= 25'd0;
            quo_q    <= '0;
            cnt_q    <= '0;
            sig_q    <= 24'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= 32'd0;
            dbz_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.operando_a;
                        b_q    <= bus.operando_b;
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        inv_q  <= 1'b0;
                        state  <= SPECIAL;
                    end
                end
                SPECIAL: begin
                    if (sp_hit) begin
                        res_q  <= sp_res;
                        inv_q  <= sp_inv;
                        dbz_q  <= sp_dbz;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        exp_q <= $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                        rem_q <= {2'b01, a_q[22:0]};
                        div_q <= {2'b01, b_q[22:0]};
                        quo_q <= '0;
                        cnt_q <= CW'(Q_BITS);
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state <= NORM;
                    end
`ifdef FP_DIV_EARLY_TERM_EN
                    else if (rem_next == 26'd0) begin
                        // Exact quotient: remaining bits are all zero, so pad and skip ahead
                        quo_q <= quo_next << (cnt_q - 1'b1);
                        cnt_q <= '0;
                        state <= NORM;
                    end
`endif
                end
                NORM: begin
                    exp_q    <= exp_norm;
                    sig_q    <= quo_norm[Q_BITS-1 -: 24];
                    guard_q  <= quo_norm[Q_BITS-25];
                    sticky_q <= (|quo_norm[Q_BITS-26:0]) | (rem_q != 26'd0);
                    state    <= ROUND;
                end
                ROUND: begin
                    res_q  <= norm_res;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - directed self-checking bench for fp_div
module tb_fp_div;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fp_div_if bus ();

    fp_div #(.Q_BITS(27)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FP_DIV_EARLY_TERM_EN
    localparam int LAT_6_2 = 6;
`else
    localparam int LAT_6_2 = 31;
`endif
    localparam int LAT_FULL = 31;
    localparam int LAT_SPEC = 2;

    // Issue one operation from IDLE and wait (bounded) for done
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [1:0] flags,
                          output int lat, output logic busy1, output logic [1:0] flags1);
        @(negedge clock);
        bus.start      = 1'b1;
        bus.operando_a = a;
        bus.operando_b = b;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        bus.start = 1'b0;
        busy1  = bus.busy;
        flags1 = {bus.div_by_zero, bus.invalid};
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        res   = bus.resultado;
        flags = {bus.div_by_zero, bus.invalid};
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.operando_a = 32'd0;
        bus.operando_b = 32'd0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.invalid} !== 4'b0000) begin
            $display("FAIL reset_ctrl: busy/done/dbz/inv=%b expected 0000",
                     {bus.busy, bus.done, bus.div_by_zero, bus.invalid});
        end else n_pass++;
        n_checks++;
        if (bus.resultado !== 32'd0) $display("FAIL reset_res: got %h expected 00000000", bus.resultado);
        else n_pass++;
        reset = 1'b0;
    endtask

    // Each row: a, b, expected result, expected {dbz,inv}, expected latency (0 = unchecked)
    task automatic test_vectors(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_res, input logic [1:0] exp_flags, input int exp_lat);
        logic [31:0] res;
        logic [1:0]  flags, flags1;
        logic        busy1;
        int          lat;
        run_op(a, b, res, flags, lat, busy1, flags1);
        n_checks++;
        if (res !== exp_res) $display("FAIL %s res: got %h expected %h", name, res, exp_res);
        else n_pass++;
        n_checks++;
        if (flags !== exp_flags) $display("FAIL %s flags{dbz,inv}: got %b expected %b", name, flags, exp_flags);
        else n_pass++;
        n_checks++;
        if ({busy1, flags1} !== 3'b100) $display("FAIL %s accept{busy,dbz,inv}: got %b expected 100", name, {busy1, flags1});
        else n_pass++;
        if (exp_lat != 0) begin
            n_checks++;
            if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            else n_pass++;
        end
    endtask

    task automatic test_normal();
        test_vectors("6/2",  32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, LAT_6_2);
        test_vectors("1/3",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00, LAT_FULL);
        test_vectors("-1/3", 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 2'b00, LAT_FULL);
        test_vectors("1.5/-1", 32'h3FC00000, 32'hBF800000, 32'hBFC00000, 2'b00, 0);
    endtask

    task automatic test_special();
        test_vectors("1/0",     32'h3F800000, 32'h00000000, 32'h7F800000, 2'b10, LAT_SPEC);
        test_vectors("0/0",     32'h00000000, 32'h00000000, 32'h7FC00000, 2'b01, LAT_SPEC);
        test_vectors("nan/1",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2'b01, LAT_SPEC);
        test_vectors("inf/inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 2'b01, LAT_SPEC);
        test_vectors("inf/-1",  32'h7F800000, 32'hBF800000, 32'hFF800000, 2'b00, LAT_SPEC);
        test_vectors("1/inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 2'b00, LAT_SPEC);
        test_vectors("-0/1",    32'h80000000, 32'h3F800000, 32'h80000000, 2'b00, LAT_SPEC);
        test_vectors("-1/0",    32'hBF800000, 32'h00000000, 32'hFF800000, 2'b10, LAT_SPEC);
        test_vectors("denorm/1", 32'h00400000, 32'h3F800000, 32'h00000000, 2'b00, LAT_SPEC);
    endtask

    task automatic test_range();
        test_vectors("overflow",  32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 2'b00, 0);
        test_vectors("underflow", 32'h00800000, 32'h7F7FFFFF, 32'h00000000, 2'b00, 0);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic busy_at_pulse;
        logic [31:0] res_mid;
        @(negedge clock);
        bus.start      = 1'b1;
        bus.operando_a = 32'h40C00000;
        bus.operando_b = 32'h40000000;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        bus.start      = 1'b1;
        bus.operando_a = 32'h3F800000;
        bus.operando_b = 32'h40400000;
        busy_at_pulse  = bus.busy;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        n_checks++;
        if (busy_at_pulse !== 1'b1) $display("FAIL ignore_busy: got %b expected 1", busy_at_pulse);
        else n_pass++;
        n_checks++;
        if (bus.resultado !== 32'h40400000) $display("FAIL ignore_res: got %h expected 40400000", bus.resultado);
        else n_pass++;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        res_mid = bus.resultado;
        n_checks++;
        if (res_mid !== 32'h40400000) $display("FAIL hold_res: got %h expected 40400000", res_mid);
        else n_pass++;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        n_checks++;
        if (bus.resultado !== 32'h3EAAAAAB) $display("FAIL second_res: got %h expected 3EAAAAAB", bus.resultado);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int seen;
        logic [31:0] res;
        logic [1:0]  flags, flags1;
        logic        busy1;
        int          lat;
        @(negedge clock);
        bus.start      = 1'b1;
        bus.operando_a = 32'h3F800000;
        bus.operando_b = 32'h40400000;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (11) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL abort_ctrl: busy/done=%b expected 00", {bus.busy, bus.done});
        else n_pass++;
        n_checks++;
        if (bus.resultado !== 32'd0) $display("FAIL abort_res: got %h expected 00000000", bus.resultado);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clock);
            if (bus.done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", seen);
        else n_pass++;
        run_op(32'h40C00000, 32'h40000000, res, flags, lat, busy1, flags1);
        n_checks++;
        if (res !== 32'h40400000) $display("FAIL after_abort_res: got %h expected 40400000", res);
        else n_pass++;
        n_checks++;
        if (lat !== LAT_6_2) $display("FAIL after_abort_latency: got %0d expected %0d", lat, LAT_6_2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
